multi_sprite_mover: RTL and testbench
=====================================

# multi_sprite_mover

Parametrised successor to the single-box mover. Maintains N_OBJ independently steered rectangular sprites on the 160x120 VGA adapter. Each sprite moves one step per move period according to its direction inputs. Only sprites whose position actually changes are erased in the background colour and redrawn. Sits between the board KEY/SW decode logic and the single vga_adapter instance, and drives its x/y/colour/plot pixel-write port.

## Interface
Parameters:
- N_OBJ, 2 — number of sprites (1..8)
- SPR_W_LOG2, 2 — sprite width = 2^SPR_W_LOG2 pixels
- SPR_H_LOG2, 2 — sprite height = 2^SPR_H_LOG2 pixels
- FRAME_DIV, 833333 — clk cycles per frame tick (60 Hz at 50 MHz)
- MOVE_FRAMES, 4 — frame ticks per move period
- INIT_Y, 50 — reset y of every sprite

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset: synchronous, active-low
- dir_left / dir_right / dir_up / dir_down  in  N_OBJ each  per-sprite direction request, bit i = sprite i; sampled at S_SCAN
- obj_colour  in  3*N_OBJ  sprite i colour at bits [3i+2:3i]
- bg_colour  in  3  erase colour
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high in any state except S_WAIT
- move_done  out  1  one-cycle pulse when a full scan of all sprites completes

## Operation
- Reset: x=0, y=0, colour=0, plot=0, busy=0, move_done=0. Sprite i position = (i*2*W, INIT_Y). Tick counters cleared. pending=0.
- Position limits: X_LIM = 160-W, Y_LIM = 120-H.
- States:
  - S_INIT_DRAW: draws every sprite in index order, W*H cycles each, then goes to S_WAIT.
  - S_WAIT: when pending=1, clear pending, set i=0, go to S_SCAN.
  - S_SCAN: 1 cycle. Compute the new position of sprite i.
    - Left and right both set: no x change. Up and down both set: no y change.
    - Step is 1 pixel; the bound rule applies (see Configuration).
    - New position equal to old: go to S_NEXT. Otherwise latch old and new positions and go to S_ERASE.
  - S_ERASE: W*H cycles, plot=1, colour=bg_colour, rectangle at old position.
  - S_DRAW: W*H cycles, plot=1, colour=obj_colour[i], rectangle at new position. The stored position updates on entry to S_DRAW.
  - S_NEXT: 1 cycle. If i=N_OBJ-1, pulse move_done and go to S_WAIT; otherwise i+1 and go to S_SCAN.
- Pixel order within a rectangle: pixel counter cnt (SPR_W_LOG2+SPR_H_LOG2 bits) runs 0..W*H-1.
  - x = base_x + cnt[SPR_W_LOG2-1:0], so column varies fastest.
  - y = base_y + cnt[upper bits].
- Tick generation:
  - The frame counter is free-running and wraps at FRAME_DIV-1, producing a frame tick.
  - The move counter counts frame ticks; every MOVE_FRAMES-th tick it sets pending.
  - Ticks continue while busy. pending is a single sticky bit, so extra move periods that elapse while busy are dropped, not queued.
- Sprite overlap is not checked. The later index draws on top.
- Direction and colour inputs are not registered for stability. The caller holds them; they are sampled at S_SCAN and used throughout S_DRAW.

## Timing
- x, y, colour and plot are registered. The first plot of a rectangle appears the cycle after entering S_ERASE or S_DRAW.
- plot is high for exactly W*H consecutive cycles per rectangle. There are no gaps between S_ERASE and S_DRAW.
- Pending set to first erase plot: 3 cycles (S_WAIT→S_SCAN→S_ERASE→output register).
- A moving sprite costs 2*W*H + 2 cycles. A stationary sprite costs 2 cycles.
- Reset mid-operation: plot drops the cycle after reset_n is sampled low. All state returns to reset values, and S_INIT_DRAW reruns after release.

## Configuration
- MSM_WRAP_EN:
  - Defined: moving right from X_LIM gives 0; left from 0 gives X_LIM; likewise y against Y_LIM.
  - Undefined: positions clamp at 0 and X_LIM/Y_LIM. A clamped request counts as no change, so the sprite is not redrawn.

## Structure
- Package msm_pkg holds:
  - SCREEN_W=160 and SCREEN_H=120
  - the state enum (S_INIT_DRAW, S_WAIT, S_SCAN, S_ERASE, S_DRAW, S_NEXT)
  - colour constants BLACK=3'b000 and WHITE=3'b111
- Sub-module msm_tick_gen (FRAME_DIV/MOVE_FRAMES counters and the pending flag). FSM, position registers and pixel counter stay in the top module.

## Test plan
All benches use FRAME_DIV=4, MOVE_FRAMES=2, N_OBJ=2, W=H=4.
- Reset release, no directions -> 32 plot cycles: sprite0 at (0,50)..(3,53), then sprite1 at (8,50)..(11,53), column fastest. No further plots; move_done pulses every period.
- dir_right[0]=1 -> 16 plots of bg_colour at x 0..3, y 50..53, then 16 plots of obj_colour[0] at x 1..4. Sprite1 is not plotted.
- Sprite0 driven to x=156 with dir_right[0] held -> without MSM_WRAP_EN it stays at 156 with no plots; with it, it is erased at 156 and drawn at x=0.
- dir_left[1]=dir_right[1]=1 and dir_up[1]=1 -> x stays 8, y goes to 49; erase at y 50..53, draw at y 49..52.
- Both sprites moving -> sprite0's erase+draw (32 cycles) completes before sprite1's S_SCAN. move_done pulses once after sprite1.
- reset_n low at plot cycle 5 of S_DRAW -> plot=0 the next cycle; after release, S_INIT_DRAW redraws at the reset positions.

Source files
------------

// File: rtl/msm_pkg.sv
// rtl/msm_pkg.sv - shared constants and state encoding for multi_sprite_mover
// Contents:
//   SCREEN_W / SCREEN_H : VGA adapter resolution (160x120)
//   BLACK / WHITE       : colour constants
//   state_t             : FSM state encoding
package msm_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    S_INIT_DRAW,
    S_WAIT,
    S_SCAN,
    S_ERASE,
    S_DRAW,
    S_NEXT
  } state_t;

endpackage

// File: rtl/msm_tick_gen.sv
// rtl/msm_tick_gen.sv - frame/move tick divider with sticky move-pending flag
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   clear_i      : consumer acknowledges the pending move period
//   pending_o    : a move period has elapsed and not yet been consumed
module msm_tick_gen #(
  parameter int FRAME_DIV   = 833333,
  parameter int MOVE_FRAMES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic pending_o
);

  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int MW = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q;
  logic [MW-1:0] move_cnt_q;
  logic          pending_q;
  logic          frame_tick;
  logic          move_tick;

  assign frame_tick = (frame_cnt_q == FRAME_LAST);
  assign move_tick  = frame_tick && (move_cnt_q == MOVE_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      move_cnt_q  <= '0;
      pending_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_tick ? '0 : frame_cnt_q + 1'b1;
      if (frame_tick) begin
        move_cnt_q <= (move_cnt_q == MOVE_LAST) ? '0 : move_cnt_q + 1'b1;
      end
      // Single sticky bit: periods that elapse while it is still set are dropped.
      // A new period arriving in the same cycle as the acknowledge wins.
      if (move_tick) begin
        pending_q <= 1'b1;
      end else if (clear_i) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/multi_sprite_mover.sv
// rtl/multi_sprite_mover.sv - N_OBJ steerable sprites driving the vga_adapter pixel port
// Ports:
//   clk, reset_n                         : clock, synchronous active-low reset
//   dir_left/right/up/down [N_OBJ-1:0]   : per-sprite direction requests (bit i = sprite i)
//   obj_colour [3*N_OBJ-1:0]             : sprite i colour at [3i+2:3i]
//   bg_colour                            : erase colour
//   x, y, colour, plot                   : registered pixel-write port
//   busy                                 : high whenever the FSM is not in S_WAIT
//   move_done                            : one-cycle pulse at the end of each full scan
// Build option: define MSM_WRAP_EN for wrap-around at the screen edges;
// the default build clamps at 0 and X_LIM/Y_LIM.
module multi_sprite_mover
  import msm_pkg::*;
#(
  parameter int N_OBJ       = 2,
  parameter int SPR_W_LOG2  = 2,
  parameter int SPR_H_LOG2  = 2,
  parameter int FRAME_DIV   = 833333,
  parameter int MOVE_FRAMES = 4,
  parameter int INIT_Y      = 50
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_OBJ-1:0]   dir_left,
  input  logic [N_OBJ-1:0]   dir_right,
  input  logic [N_OBJ-1:0]   dir_up,
  input  logic [N_OBJ-1:0]   dir_down,
  input  logic [3*N_OBJ-1:0] obj_colour,
  input  logic [2:0]         bg_colour,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               plot,
  output logic               busy,
  output logic               move_done
);

  localparam int W  = 1 << SPR_W_LOG2;
  localparam int H  = 1 << SPR_H_LOG2;
  localparam int CW = SPR_W_LOG2 + SPR_H_LOG2;
  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [7:0]    X_LIM    = 8'(SCREEN_W - W);
  localparam logic [6:0]    Y_LIM    = 7'(SCREEN_H - H);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OBJ - 1);
  localparam logic [CW-1:0] CNT_LAST = '1;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    pos_x_q [N_OBJ];
  logic [6:0]    pos_y_q [N_OBJ];
  logic [7:0]    old_x_q, new_x_q;
  logic [6:0]    old_y_q, new_y_q;
  logic [7:0]    x_q;
  logic [6:0]    y_q;
  logic [2:0]    colour_q;
  logic          plot_q, busy_q, move_done_q;

  logic          pending;
  logic          clear_pending;
  logic [7:0]    cur_x, nx_d, base_x, px;
  logic [6:0]    cur_y, ny_d, base_y, py;
  logic [2:0]    pix_colour;
  logic          go_l, go_r, go_u, go_d;

  msm_tick_gen #(
    .FRAME_DIV   (FRAME_DIV),
    .MOVE_FRAMES (MOVE_FRAMES)
  ) u_tick_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (clear_pending),
    .pending_o (pending)
  );

  assign clear_pending = (state_q == S_WAIT) && pending;

  // Candidate position of the sprite under scan. Opposing requests cancel.
  always_comb begin
    cur_x = pos_x_q[idx_q];
    cur_y = pos_y_q[idx_q];
    go_l  = dir_left[idx_q]  & ~dir_right[idx_q];
    go_r  = dir_right[idx_q] & ~dir_left[idx_q];
    go_u  = dir_up[idx_q]    & ~dir_down[idx_q];
    go_d  = dir_down[idx_q]  & ~dir_up[idx_q];
    nx_d  = cur_x;
    ny_d  = cur_y;
`ifdef MSM_WRAP_EN
    if (go_r)      nx_d = (cur_x >= X_LIM) ? 8'd0 : cur_x + 8'd1;
    else if (go_l) nx_d = (cur_x == 8'd0) ? X_LIM : cur_x - 8'd1;
    if (go_d)      ny_d = (cur_y >= Y_LIM) ? 7'd0 : cur_y + 7'd1;
    else if (go_u) ny_d = (cur_y == 7'd0) ? Y_LIM : cur_y - 7'd1;
`else
    if (go_r && (cur_x < X_LIM))     nx_d = cur_x + 8'd1;
    else if (go_l && (cur_x != 8'd0)) nx_d = cur_x - 8'd1;
    if (go_d && (cur_y < Y_LIM))     ny_d = cur_y + 7'd1;
    else if (go_u && (cur_y != 7'd0)) ny_d = cur_y - 7'd1;
`endif
  end

  // Pixel address: column comes from the low counter bits so it varies fastest.
  always_comb begin
    case (state_q)
      S_ERASE: begin
        base_x     = old_x_q;
        base_y     = old_y_q;
        pix_colour = bg_colour;
      end
      S_DRAW: begin
        base_x     = new_x_q;
        base_y     = new_y_q;
        pix_colour = obj_colour[3*idx_q +: 3];
      end
      default: begin
        base_x     = cur_x;
        base_y     = cur_y;
        pix_colour = obj_colour[3*idx_q +: 3];
      end
    endcase
    px = base_x + 8'(cnt_q[SPR_W_LOG2-1:0]);
    py = base_y + 7'(cnt_q[CW-1:SPR_W_LOG2]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_INIT_DRAW;
      idx_q       <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < N_OBJ; k++) begin
        pos_x_q[k] <= 8'(k * 2 * W);
        pos_y_q[k] <= 7'(INIT_Y);
      end
      old_x_q     <= '0;
      old_y_q     <= '0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= BLACK;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      move_done_q <= 1'b0;
    end else begin
      plot_q      <= 1'b0;
      move_done_q <= 1'b0;
      case (state_q)
        S_INIT_DRAW: begin
          busy_q   <= 1'b1;
          plot_q   <= 1'b1;
          x_q      <= px;
          y_q      <= py;
          colour_q <= pix_colour;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= S_WAIT;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (pending) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          cnt_q <= '0;
          if ((nx_d == cur_x) && (ny_d == cur_y)) begin
            state_q <= S_NEXT;
          end else begin
            old_x_q <= cur_x;
            old_y_q <= cur_y;
            new_x_q <= nx_d;
            new_y_q <= ny_d;
            state_q <= S_ERASE;
          end
        end
        S_ERASE, S_DRAW: begin
          plot_q   <= 1'b1;
          x_q      <= px;
          y_q      <= py;
          colour_q <= pix_colour;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (state_q == S_ERASE) begin
              pos_x_q[idx_q] <= new_x_q;
              pos_y_q[idx_q] <= new_y_q;
              state_q        <= S_DRAW;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            move_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_WAIT;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_SCAN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_WAIT;
        end
      endcase
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign move_done = move_done_q;

endmodule

// File: tb/tb_multi_sprite_mover.sv
// tb/tb_multi_sprite_mover.sv - self-checking bench for multi_sprite_mover
module tb_multi_sprite_mover;

  localparam logic [2:0] C0 = 3'b011;
  localparam logic [2:0] C1 = 3'b101;
  localparam logic [2:0] BG = 3'b001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dir_left = '0, dir_right = '0, dir_up = '0, dir_down = '0;
  logic [5:0] obj_colour = {C1, C0};
  logic [2:0] bg_colour = BG;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, move_done;

  multi_sprite_mover #(
    .N_OBJ(2), .SPR_W_LOG2(2), .SPR_H_LOG2(2),
    .FRAME_DIV(4), .MOVE_FRAMES(2), .INIT_Y(50)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .dir_left(dir_left), .dir_right(dir_right), .dir_up(dir_up), .dir_down(dir_down),
    .obj_colour(obj_colour), .bg_colour(bg_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .move_done(move_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dl, dr, du, dd;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] x1;
    logic [6:0] y1;
  } vec_t;

  vec_t       vecs[8];
  int         tests_run = 0;
  int         tests_failed = 0;
  bit         timed_out = 0;
  logic [7:0] ex[2];
  logic [6:0] ey[2];
  logic [17:0] obs[$];
  logic [17:0] expq[$];
  int bursts, burst_min, burst_max, unbusy_plots, first_plot_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic add_rect(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c);
    for (int p = 0; p < 16; p++) expq.push_back({bx + 8'(p % 4), by + 7'(p / 4), c});
  endtask

  // Records every plotted pixel {x,y,colour} until the next move_done pulse.
  task automatic collect();
    logic prev;
    bit   done;
    int   cur_len;
    obs.delete();
    bursts = 0; burst_min = 1000; burst_max = 0; unbusy_plots = 0;
    first_plot_cyc = -1; prev = 1'b0; cur_len = 0; done = 0;
    if (timed_out) return;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      if (plot) begin
        obs.push_back({x, y, colour});
        if (!busy) unbusy_plots++;
        if (first_plot_cyc < 0) first_plot_cyc = cyc;
        cur_len++;
      end
      if (!plot && prev) begin
        bursts++;
        if (cur_len < burst_min) burst_min = cur_len;
        if (cur_len > burst_max) burst_max = cur_len;
        cur_len = 0;
      end
      prev = plot;
      if (move_done) begin
        done = 1;
        check("busy_at_move_done", 32'(busy), 32'd0);
      end
    end
    if (!done) begin
      check("move_done_timeout", 32'd0, 32'd1);
      timed_out = 1;
    end
  endtask

  task automatic verify(input string name, input int exp_bursts);
    int bad;
    int k;
    bad = -1;
    check({name, " plot_count"}, obs.size(), expq.size());
    for (int i = 0; i < obs.size() && i < expq.size(); i++)
      if (bad < 0 && obs[i] !== expq[i]) bad = i;
    if (obs.size() > 0 && expq.size() > 0) begin
      k = (bad >= 0) ? bad : ((obs.size() < expq.size()) ? obs.size() : expq.size()) - 1;
      check({name, " pixel{x,y,c}"}, 32'(obs[k]), 32'(expq[k]));
    end
    check({name, " bursts"}, bursts, exp_bursts);
    if (exp_bursts > 0) begin
      check({name, " burst_min_len"}, burst_min, 32);
      check({name, " burst_max_len"}, burst_max, 32);
    end
  endtask

  task automatic run_period(input string name, input logic [1:0] dl, input logic [1:0] dr,
                            input logic [1:0] du, input logic [1:0] dd,
                            input logic [7:0] nx0, input logic [6:0] ny0,
                            input logic [7:0] nx1, input logic [6:0] ny1);
    logic [7:0] nx[2];
    logic [6:0] ny[2];
    int moved;
    if (timed_out) return;
    nx[0] = nx0; ny[0] = ny0; nx[1] = nx1; ny[1] = ny1;
    moved = 0;
    expq.delete();
    for (int s = 0; s < 2; s++) begin
      if (nx[s] !== ex[s] || ny[s] !== ey[s]) begin
        add_rect(ex[s], ey[s], BG);
        add_rect(nx[s], ny[s], (s == 0) ? C0 : C1);
        moved++;
      end
    end
    dir_left = dl; dir_right = dr; dir_up = du; dir_down = dd;
    collect();
    verify(name, moved);
    check({name, " plot_while_idle"}, unbusy_plots, 0);
    for (int s = 0; s < 2; s++) begin
      ex[s] = nx[s];
      ey[s] = ny[s];
    end
  endtask

  task automatic expect_init(input string name);
    expq.delete();
    add_rect(8'd0, 7'd50, C0);
    add_rect(8'd8, 7'd50, C1);
    collect();
    verify(name, 1);
    check({name, " first_plot_latency"}, first_plot_cyc, 1);
    ex[0] = 8'd0; ey[0] = 7'd50; ex[1] = 8'd8; ey[1] = 7'd50;
  endtask

  initial begin
    int  n;
    bit  got;

    vecs[0] = '{2'b00, 2'b01, 2'b00, 2'b00, 8'd1, 7'd50, 8'd8, 7'd50};
    vecs[1] = '{2'b10, 2'b10, 2'b10, 2'b00, 8'd1, 7'd50, 8'd8, 7'd49};
    vecs[2] = '{2'b00, 2'b01, 2'b00, 2'b10, 8'd2, 7'd50, 8'd8, 7'd50};
    vecs[3] = '{2'b01, 2'b00, 2'b01, 2'b00, 8'd1, 7'd49, 8'd8, 7'd50};
    vecs[4] = '{2'b01, 2'b00, 2'b00, 2'b00, 8'd0, 7'd49, 8'd8, 7'd50};
    vecs[5] = '{2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 7'd49, 8'd8, 7'd50};
    vecs[6] = '{2'b11, 2'b11, 2'b11, 2'b11, 8'd0, 7'd49, 8'd8, 7'd50};
    vecs[7] = '{2'b00, 2'b10, 2'b00, 2'b01, 8'd0, 7'd50, 8'd9, 7'd50};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset x", 32'(x), 32'd0);
    check("reset y", 32'(y), 32'd0);
    check("reset colour", 32'(colour), 32'd0);
    check("reset plot", 32'(plot), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset move_done", 32'(move_done), 32'd0);
    reset_n = 1'b1;

    expect_init("init");

    for (int v = 0; v < 8; v++)
      run_period($sformatf("vec%0d", v), vecs[v].dl, vecs[v].dr, vecs[v].du, vecs[v].dd,
                 vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1);

    // Left edge, then walk to the right edge
`ifdef MSM_WRAP_EN
    run_period("left_edge", 2'b01, 2'b00, 2'b00, 2'b00, 8'd156, 7'd50, 8'd9, 7'd50);
    run_period("wrap_back", 2'b00, 2'b01, 2'b00, 2'b00, 8'd0, 7'd50, 8'd9, 7'd50);
`else
    run_period("left_edge", 2'b01, 2'b00, 2'b00, 2'b00, 8'd0, 7'd50, 8'd9, 7'd50);
`endif
    for (int k = 1; k <= 156; k++)
      run_period($sformatf("walk_right%0d", k), 2'b00, 2'b01, 2'b00, 2'b00,
                 8'(k), 7'd50, 8'd9, 7'd50);
`ifdef MSM_WRAP_EN
    run_period("right_edge", 2'b00, 2'b01, 2'b00, 2'b00, 8'd0, 7'd50, 8'd9, 7'd50);
    run_period("wrap_back2", 2'b01, 2'b00, 2'b00, 2'b00, 8'd156, 7'd50, 8'd9, 7'd50);
`else
    run_period("right_edge", 2'b00, 2'b01, 2'b00, 2'b00, 8'd156, 7'd50, 8'd9, 7'd50);
`endif

    // Sprite0 up to the top edge while sprite1 heads for the bottom edge
    for (int k = 1; k <= 50; k++)
      run_period($sformatf("walk_ud%0d", k), 2'b00, 2'b00, 2'b01, 2'b10,
                 8'd156, 7'(50 - k), 8'd9, 7'(50 + k));
    for (int k = 1; k <= 16; k++)
      run_period($sformatf("walk_down%0d", k), 2'b00, 2'b00, 2'b00, 2'b10,
                 8'd156, 7'd0, 8'd9, 7'(100 + k));
`ifdef MSM_WRAP_EN
    run_period("y_edges", 2'b00, 2'b00, 2'b01, 2'b10, 8'd156, 7'd116, 8'd9, 7'd0);
`else
    run_period("y_edges", 2'b00, 2'b00, 2'b01, 2'b10, 8'd156, 7'd0, 8'd9, 7'd116);
`endif

    // Reset asserted on the 5th plot of S_DRAW
    if (!timed_out) begin
      dir_left = 2'b01; dir_right = 2'b00; dir_up = 2'b00; dir_down = 2'b00;
      n = 0; got = 0;
      for (int c = 0; c < 400 && !got; c++) begin
        @(negedge clk);
        if (plot) n++;
        if (n == 21) got = 1;
      end
      check("midreset reached_draw5", 32'(got), 32'd1);
      check("midreset draw_colour", 32'(colour), 32'(C0));
      reset_n = 1'b0;
      @(negedge clk);
      check("midreset plot", 32'(plot), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset x", 32'(x), 32'd0);
      check("midreset y", 32'(y), 32'd0);
      dir_left = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      expect_init("reinit");
      run_period("after_reinit", 2'b00, 2'b01, 2'b00, 2'b00, 8'd1, 7'd50, 8'd8, 7'd50);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
